// File: rtl/window_gen3x3_pkg.sv
// Shared types and constants for the 3x3 window generator.
// No logic; state encoding, pixel/grid widths and grid byte addressing.
package cartoon_pkg;

   localparam int PIX_W  = 8;
   localparam int GRID_W = 9 * PIX_W;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM,
      DONE
   } state_e;

   // Byte slot of window row r (0 = top/oldest line) and column c (0 = newest pixel).
   function automatic int byte_idx(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/window_gen3x3_if.sv
// Pixel-in / grid-out bundle of the 3x3 window generator.
// The master drives pixels and samples grids; the slave is the generator.
interface window_gen3x3_if #(
   parameter int ADDR_W = 10
);

   logic [cartoon_pkg::PIX_W-1:0]  iPixel;
   logic                           iPixelValid;
   logic                           iStartFrame;
   logic [cartoon_pkg::GRID_W-1:0] oGrid;
   logic                           oGridValid;
   logic [ADDR_W-1:0]              oCenterX;
   logic [ADDR_W-1:0]              oCenterY;
   logic                           oFrameDone;

   modport master (
      output iPixel, iPixelValid, iStartFrame,
      input  oGrid, oGridValid, oCenterX, oCenterY, oFrameDone
   );

   modport slave (
      input  iPixel, iPixelValid, iStartFrame,
      output oGrid, oGridValid, oCenterX, oCenterY, oFrameDone
   );

endinterface

// File: rtl/window_gen3x3_line_buffer.sv
// One-line pixel store: combinational read and write share the same address.
// Read returns the old entry in the cycle it is overwritten; no backpressure.
module line_buffer
   import cartoon_pkg::*;
#(
   parameter int DEPTH = 640
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [PIX_W-1:0]         wr_dat,
   output logic [PIX_W-1:0]         rd_dat
);

   logic [PIX_W-1:0] mem_q [DEPTH];

   assign rd_dat = mem_q[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[addr] <= wr_dat;
      end
   end

endmodule

// File: rtl/window_gen3x3.sv
// Raster pixel stream to sliding 3x3 window; one grid per interior pixel.
// Latency 1 cycle from pixel to grid; input gaps allowed, no backpressure.
module window_gen3x3
   import cartoon_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int ADDR_W = 10
) (
   input  logic           clk,
   input  logic           n_rst,
   window_gen3x3_if.slave bus
);

   localparam int                LB_AW    = $clog2(WIDTH);
   localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(WIDTH - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   col_q, col_d;
   logic [ADDR_W-1:0]   row_q, row_d;
   logic [GRID_W-1:0]   win_q, win_d;
   logic [GRID_W-1:0]   grid_q, grid_d;
   logic                grid_vld_q, grid_vld_d;
   logic [ADDR_W-1:0]   cx_q, cx_d;
   logic [ADDR_W-1:0]   cy_q, cy_d;
   logic                done_q, done_d;

   logic                start;
   logic                accept;
   logic [ADDR_W-1:0]   x;
   logic [ADDR_W-1:0]   y;
   logic [PIX_W-1:0]    lb0_rd;
   logic [PIX_W-1:0]    lb1_rd;

   // A start pixel is always (0,0), even when it aborts a frame in flight.
   assign start  = bus.iPixelValid & bus.iStartFrame;
   assign accept = bus.iPixelValid & (bus.iStartFrame | (state_q == FILL) | (state_q == STREAM));
   assign x      = start ? '0 : col_q;
   assign y      = start ? '0 : row_q;

   line_buffer #(.DEPTH(WIDTH)) u_lb0 (
      .clk    (clk),
      .wr_en  (accept & n_rst),
      .addr   (x[LB_AW-1:0]),
      .wr_dat (bus.iPixel),
      .rd_dat (lb0_rd)
   );

   // Second line is fed by what the first line held at this column.
   line_buffer #(.DEPTH(WIDTH)) u_lb1 (
      .clk    (clk),
      .wr_en  (accept & n_rst),
      .addr   (x[LB_AW-1:0]),
      .wr_dat (lb0_rd),
      .rd_dat (lb1_rd)
   );

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      win_d      = win_q;
      grid_d     = grid_q;
      grid_vld_d = 1'b0;
      cx_d       = cx_q;
      cy_d       = cy_q;
      done_d     = 1'b0;

      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win_d[PIX_W*byte_idx(r, 2) +: PIX_W] = win_q[PIX_W*byte_idx(r, 1) +: PIX_W];
            win_d[PIX_W*byte_idx(r, 1) +: PIX_W] = win_q[PIX_W*byte_idx(r, 0) +: PIX_W];
         end
         win_d[PIX_W*byte_idx(0, 0) +: PIX_W] = lb1_rd;
         win_d[PIX_W*byte_idx(1, 0) +: PIX_W] = lb0_rd;
         win_d[PIX_W*byte_idx(2, 0) +: PIX_W] = bus.iPixel;

         if (x == LAST_COL) begin
            col_d = '0;
            row_d = (y == LAST_ROW) ? '0 : y + ONE;
         end else begin
            col_d = x + ONE;
            row_d = y;
         end

         if (start) begin
            state_d = FILL;
         end else if (state_q == FILL && x == LAST_COL && y == ONE) begin
            state_d = STREAM;
         end else if (state_q == STREAM && x == LAST_COL && y == LAST_ROW) begin
            state_d = DONE;
            done_d  = 1'b1;
         end

         if (x >= TWO && y >= TWO) begin
            grid_d     = win_d;
            grid_vld_d = 1'b1;
            cx_d       = x - ONE;
            cy_d       = y - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         col_q      <= '0;
         row_q      <= '0;
         win_q      <= '0;
         grid_q     <= '0;
         grid_vld_q <= 1'b0;
         cx_q       <= '0;
         cy_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         win_q      <= win_d;
         grid_q     <= grid_d;
         grid_vld_q <= grid_vld_d;
         cx_q       <= cx_d;
         cy_q       <= cy_d;
         done_q     <= done_d;
      end
   end

   assign bus.oGrid      = grid_q;
   assign bus.oGridValid = grid_vld_q;
   assign bus.oCenterX   = cx_q;
   assign bus.oCenterY   = cy_q;
   assign bus.oFrameDone = done_q;

endmodule

// File: tb/tb_window_gen3x3.sv
// Directed bench for window_gen3x3 on a 4x4 frame: per-cycle vectors with
// expected outputs derived from pixel coordinates, plus frame-level checks.
module tb_window_gen3x3;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic n_rst;

   always #5 clk = ~clk;

   window_gen3x3_if #(.ADDR_W(AW)) bus ();

   window_gen3x3 #(
      .WIDTH  (W),
      .HEIGHT (H),
      .ADDR_W (AW)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]    pix;
      logic          vld;
      logic          start;
      logic          rst_n;
      logic          exp_vld;
      logic          exp_done;
      logic [71:0]   exp_grid;
      logic [AW-1:0] exp_cx;
      logic [AW-1:0] exp_cy;
   } vec_t;

   vec_t          vecs[$];
   logic [71:0]   hold_grid;
   logic [AW-1:0] hold_cx;
   logic [AW-1:0] hold_cy;
   int            n_vec;
   int            n_bad;
   int            f1_lo;
   int            f1_hi;
   int            f1_cnt;
   logic [71:0]   f1_first;
   logic [71:0]   first_exp;

   // Window around centre (cx,cy): byte 3r+c holds pixel (cx+1-c, cy-1+r).
   function automatic logic [71:0] model_grid(input logic [7:0] base, input int cx, input int cy);
      logic [71:0] g;
      g = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            g[8*(3*r+c) +: 8] = base + 8'(16 * (cy - 1 + r) + (cx + 1 - c));
         end
      end
      return g;
   endfunction

   function automatic void push(input logic [7:0] pix, input logic vld, input logic start,
                                input logic rst_n, input logic gv, input logic [71:0] g,
                                input int cx, input int cy, input logic done);
      vec_t v;
      if (!rst_n) begin
         hold_grid = '0;
         hold_cx   = '0;
         hold_cy   = '0;
      end else if (gv) begin
         hold_grid = g;
         hold_cx   = AW'(cx);
         hold_cy   = AW'(cy);
      end
      v.pix      = pix;
      v.vld      = vld;
      v.start    = start;
      v.rst_n    = rst_n;
      v.exp_vld  = gv & rst_n;
      v.exp_done = done & rst_n;
      v.exp_grid = hold_grid;
      v.exp_cx   = hold_cx;
      v.exp_cy   = hold_cy;
      vecs.push_back(v);
   endfunction

   // Pixels first..last of a frame in raster order; gap cycles carry a stray start.
   function automatic void push_frame(input logic [7:0] base, input bit gaps,
                                      input int first, input int last);
      for (int i = first; i <= last; i++) begin
         int x;
         int y;
         x = i % W;
         y = i / W;
         push(base + 8'(16 * y + x), 1'b1, i == 0, 1'b1, (x >= 2) && (y >= 2),
              model_grid(base, x - 1, y - 1), x - 1, y - 1, i == W * H - 1);
         if (gaps) begin
            push(8'hEE, 1'b0, 1'b1, 1'b1, 1'b0, '0, 0, 0, 1'b0);
         end
      end
   endfunction

   function automatic void push_idle(input int n);
      for (int i = 0; i < n; i++) begin
         push(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, '0, 0, 0, 1'b0);
      end
   endfunction

   function automatic void push_ignored(input int n);
      for (int i = 0; i < n; i++) begin
         push(8'hA5 + 8'(i), 1'b1, 1'b0, 1'b1, 1'b0, '0, 0, 0, 1'b0);
      end
   endfunction

   initial begin
      n_rst           = 1'b0;
      bus.iPixel      = '0;
      bus.iPixelValid = 1'b0;
      bus.iStartFrame = 1'b0;
      n_vec           = 0;
      n_bad           = 0;
      f1_cnt          = 0;
      f1_first        = '0;
      hold_grid       = '0;
      hold_cx         = '0;
      hold_cy         = '0;
      first_exp       = 72'h20_21_22_10_11_12_00_01_02;

      // Reset, then a continuous frame.
      push(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 0, 1'b0);
      push(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0, 0, 1'b0);
      f1_lo = vecs.size();
      push_frame(8'h00, 1'b0, 0, W * H - 1);
      f1_hi = vecs.size() - 1;
      push_idle(2);
      // Same frame with a gap after every pixel.
      push_frame(8'h00, 1'b1, 0, W * H - 1);
      push_idle(2);
      // Valid pixels without a start after reset are ignored.
      push(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0, 0, 1'b0);
      push_ignored(5);
      push_idle(1);
      push_frame(8'h00, 1'b0, 0, W * H - 1);
      push_idle(1);
      // Abort frame A at (1,2) with the first pixel of frame B.
      push_frame(8'h00, 1'b0, 0, 8);
      push_frame(8'h80, 1'b0, 0, W * H - 1);
      push_idle(2);
      // Start on the final pixel position: restart, no frame-done for the old frame.
      push_frame(8'h40, 1'b0, 0, W * H - 2);
      push_frame(8'h60, 1'b0, 0, W * H - 1);
      push_idle(2);
      // Reset at pixel (2,2), then ignored pixels in IDLE and a clean frame.
      push_frame(8'h00, 1'b0, 0, 9);
      push(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, '0, 0, 0, 1'b0);
      push_ignored(2);
      push_frame(8'h00, 1'b0, 0, W * H - 1);
      push_idle(2);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         n_rst           = vecs[i].rst_n;
         bus.iPixel      = vecs[i].pix;
         bus.iPixelValid = vecs[i].vld;
         bus.iStartFrame = vecs[i].start;
         @(posedge clk);
         #1;
         n_vec++;
         if (bus.oGridValid !== vecs[i].exp_vld || bus.oFrameDone !== vecs[i].exp_done ||
             bus.oGrid !== vecs[i].exp_grid || bus.oCenterX !== vecs[i].exp_cx ||
             bus.oCenterY !== vecs[i].exp_cy) begin
            n_bad++;
            $display("FAIL vec %0d: got vld=%0b done=%0b cx=%0d cy=%0d grid=%h, expected vld=%0b done=%0b cx=%0d cy=%0d grid=%h",
                     i, bus.oGridValid, bus.oFrameDone, bus.oCenterX, bus.oCenterY, bus.oGrid,
                     vecs[i].exp_vld, vecs[i].exp_done, vecs[i].exp_cx, vecs[i].exp_cy,
                     vecs[i].exp_grid);
         end
         if (i >= f1_lo && i <= f1_hi && bus.oGridValid === 1'b1) begin
            if (f1_cnt == 0) begin
               f1_first = bus.oGrid;
            end
            f1_cnt++;
         end
      end

      n_vec++;
      if (f1_cnt != (W - 2) * (H - 2)) begin
         n_bad++;
         $display("FAIL grid_count: got %0d grids, expected %0d", f1_cnt, (W - 2) * (H - 2));
      end
      n_vec++;
      if (f1_first !== first_exp) begin
         n_bad++;
         $display("FAIL first_grid: got %h, expected %h", f1_first, first_exp);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
